// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] PERIPH_START_ADDR = 32'h1A10_0000;
  localparam logic [31:0] PERIPH_END_ADDR   = 32'h1A11_7FFF;

  // True when the byte address falls inside the peripheral window (inclusive).
  function automatic logic in_periph_window(input logic [63:0] a);
    return (a >= {32'h0, PERIPH_START_ADDR}) && (a <= {32'h0, PERIPH_END_ADDR});
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-phase watchdog for the APB master bridge.
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count stalled ACCESS cycles, saturating at the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // Fires on the stalled cycle whose increment reaches the limit, so the
  // transfer spends exactly TIMEOUT_CYCLES cycles in ACCESS before aborting.
  always_comb begin
    expired = (TIMEOUT_CYCLES != 0) && enable &&
              ((32'(count) + 32'd1) >= TIMEOUT_CYCLES);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Core request/response to APB master bridge with address window check
// and ACCESS-phase timeout.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // core side
  input  logic                      req,
  output logic                      gnt,
  input  logic                      we,
  input  logic [APB_ADDR_WIDTH-1:0] addr,
  input  logic [APB_DATA_WIDTH-1:0] wdata,
  output logic                      rvalid,
  output logic [APB_DATA_WIDTH-1:0] rdata,
  output logic                      err,
  // APB master side
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  apb_state_e state, state_next;
  logic       in_window;
  logic       accept;
  logic       expired;
  logic       to_clear;
  logic       to_enable;

  assign in_window = in_periph_window(64'(addr));
  assign accept    = req && (state == IDLE);
  assign to_clear  = (state == SETUP);
  assign to_enable = (state == ACCESS) && !pready;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and phase-decoded outputs; pready is checked before the
  // timeout so a same-cycle pready completes normally.
  always_comb begin
    state_next = state;
    gnt        = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    rvalid     = 1'b0;
    unique case (state)
      IDLE: begin
        gnt = req;
        if (req) state_next = in_window ? SETUP : RESP;
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || expired) state_next = RESP;
      end
      RESP: begin
        rvalid     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transfer attributes latched on acceptance; response captured on completion,
  // on an out-of-window decode, or on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      paddr  <= addr;
      pwdata <= wdata;
      pwrite <= we;
      if (!in_window) begin
        rdata <= '0;
        err   <= 1'b1;
      end
    end else if (state == ACCESS) begin
      if (pready) begin
        rdata <= pwrite ? '0 : prdata;
        err   <= pslverr;
      end else if (expired) begin
        rdata <= '0;
        err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a cycle timeline of stimulus and
// expected outputs is planned up front from the transfer rules, then played
// against the DUT and compared every cycle.
module tb_apb_master_bridge;

  localparam int T    = 8;
  localparam int NCYC = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata, paddr, pwdata, prdata;
  logic        pwrite, psel, penable;
  logic        pready = 1'b0, pslverr = 1'b0;

  int tests = 0;
  int failed = 0;
  int cyc = -1;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .gnt(gnt), .we(we), .addr(addr), .wdata(wdata),
    .rvalid(rvalid), .rdata(rdata), .err(err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // stimulus timeline
  logic        s_rstn[NCYC], s_req[NCYC], s_we[NCYC], s_pready[NCYC], s_pslverr[NCYC];
  logic [31:0] s_addr[NCYC], s_wdata[NCYC], s_prdata[NCYC];
  // expected timeline
  logic        e_gnt[NCYC], e_psel[NCYC], e_penable[NCYC], e_rvalid[NCYC], e_err[NCYC];
  logic        e_pwrite[NCYC], e_rst[NCYC];
  logic [31:0] e_rdata[NCYC], e_paddr[NCYC], e_pwdata[NCYC];

  typedef struct {
    int          c;
    logic [31:0] rd;
    logic        er;
    int          acc;
  } rec_t;
  rec_t recs[$];
  int   acc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Plan one transfer accepted at cycle s; pready rises on ACCESS cycle delay+1.
  task automatic plan(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int delay, input logic slv, input logic [31:0] rd,
                      input logic hold, output int nxt);
    logic win, abort;
    int   acc, n_acc, r;
    win = (a >= 32'h1A10_0000) && (a <= 32'h1A11_7FFF);
    s_req[s] = 1'b1; s_we[s] = w; s_addr[s] = a; s_wdata[s] = d;
    e_gnt[s] = 1'b1;
    if (!win) begin
      r = s + 1;
      e_err[r] = 1'b1;
      e_rdata[r] = 32'h0;
    end else begin
      acc   = delay + 1;
      abort = (T != 0) && (acc > T);
      n_acc = abort ? T : acc;
      for (int k = s + 1; k <= s + 1 + n_acc; k++) begin
        e_psel[k] = 1'b1; e_paddr[k] = a; e_pwdata[k] = d; e_pwrite[k] = w;
        if (k > s + 1) e_penable[k] = 1'b1;
      end
      if (!abort) begin
        s_pready[s + 1 + acc] = 1'b1;
        s_pslverr[s + 1 + acc] = slv;
        s_prdata[s + 1 + acc] = rd;
      end
      r = s + 2 + n_acc;
      e_err[r]   = abort | slv;
      e_rdata[r] = (abort || w) ? 32'h0 : rd;
    end
    e_rvalid[r] = 1'b1;
    nxt = r + 1;
    if (hold) for (int k = s + 1; k < nxt; k++) begin
      s_req[k] = 1'b1; s_we[k] = w; s_addr[k] = a; s_wdata[k] = d;
    end
  endtask

  // Reset asserted for n cycles from c; anything planned from c to upto is abandoned.
  task automatic reset_at(input int c, input int n, input int upto);
    for (int k = c; k <= upto; k++) begin
      e_psel[k] = 1'b0; e_penable[k] = 1'b0; e_rvalid[k] = 1'b0; e_gnt[k] = 1'b0;
      s_pready[k] = 1'b0; s_req[k] = 1'b0;
    end
    for (int k = c; k < c + n; k++) begin
      s_rstn[k] = 1'b0; e_rst[k] = 1'b1;
    end
  endtask

  // Per-cycle compare against the planned timeline, plus response recording.
  always @(negedge clk) begin
    if (cyc >= 0 && cyc < NCYC) begin
      chk("gnt", 32'(gnt), 32'(e_gnt[cyc]));
      chk("psel", 32'(psel), 32'(e_psel[cyc]));
      chk("penable", 32'(penable), 32'(e_penable[cyc]));
      chk("rvalid", 32'(rvalid), 32'(e_rvalid[cyc]));
      if (e_rvalid[cyc]) begin
        chk("rdata", rdata, e_rdata[cyc]);
        chk("err", 32'(err), 32'(e_err[cyc]));
      end
      if (e_psel[cyc]) begin
        chk("paddr", paddr, e_paddr[cyc]);
        chk("pwdata", pwdata, e_pwdata[cyc]);
        chk("pwrite", 32'(pwrite), 32'(e_pwrite[cyc]));
      end
      if (e_rst[cyc]) begin
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pwrite", 32'(pwrite), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
      end
      if (!rst_n) acc_cnt = 0;
      else if (psel && penable) acc_cnt++;
      if (rvalid) begin
        recs.push_back('{c: cyc, rd: rdata, er: err, acc: acc_cnt});
        acc_cnt = 0;
      end
    end
  end

  initial begin
    int nx;
    int          x_cyc[10] = '{7, 17, 20, 32, 44, 50, 54, 57, 64, 75};
    logic [31:0] x_rd[10]  = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 32'h55AA_1234,
                               32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0BAD_CAFE, 32'h1357_9BDF};
    logic        x_er[10]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int          x_acc[10] = '{1, 6, 0, 8, 8, 2, 1, 0, 3, 1};

    for (int k = 0; k < NCYC; k++) begin
      s_rstn[k] = (k >= 3); s_req[k] = 1'b0; s_we[k] = 1'b0; s_pready[k] = 1'b0;
      s_pslverr[k] = 1'b0; s_addr[k] = 32'h0; s_wdata[k] = 32'h0; s_prdata[k] = 32'hFFFF_FFFF;
      e_gnt[k] = 1'b0; e_psel[k] = 1'b0; e_penable[k] = 1'b0; e_rvalid[k] = 1'b0;
      e_err[k] = 1'b0; e_pwrite[k] = 1'b0; e_rst[k] = (k < 3);
      e_rdata[k] = 32'h0; e_paddr[k] = 32'h0; e_pwdata[k] = 32'h0;
    end

    plan(4,  1'b0, 32'h1A10_1000, 32'h0,         0,  1'b0, 32'hCAFE_F00D, 1'b0, nx);
    plan(9,  1'b1, 32'h1A10_3004, 32'h1234_5678, 5,  1'b0, 32'h6666_6666, 1'b0, nx);
    plan(19, 1'b0, 32'h2000_0000, 32'h0,         0,  1'b0, 32'h0,         1'b0, nx);
    plan(22, 1'b0, 32'h1A10_0010, 32'h0,         20, 1'b0, 32'h0,         1'b0, nx);
    plan(34, 1'b0, 32'h1A10_0020, 32'h0,         7,  1'b0, 32'h55AA_1234, 1'b0, nx);
    plan(46, 1'b0, 32'h1A11_7FFC, 32'h0,         1,  1'b1, 32'hDEAD_BEEF, 1'b1, nx);
    plan(nx, 1'b1, 32'h1A11_7FFF, 32'hA5A5_A5A5, 0,  1'b0, 32'h7777_7777, 1'b0, nx);
    plan(56, 1'b0, 32'h1A11_8000, 32'h0,         0,  1'b0, 32'h0,         1'b0, nx);
    plan(59, 1'b0, 32'h1A10_0000, 32'h0,         2,  1'b0, 32'h0BAD_CAFE, 1'b0, nx);
    plan(66, 1'b0, 32'h1A10_2000, 32'h0,         10, 1'b0, 32'h0,         1'b0, nx);
    reset_at(70, 2, NCYC - 1);
    plan(72, 1'b0, 32'h1A10_1004, 32'h0,         0,  1'b0, 32'h1357_9BDF, 1'b0, nx);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      cyc = c;
      #1;
      rst_n = s_rstn[c]; req = s_req[c]; we = s_we[c]; addr = s_addr[c]; wdata = s_wdata[c];
      pready = s_pready[c]; pslverr = s_pslverr[c]; prdata = s_prdata[c];
    end
    @(negedge clk);
    #1;

    chk("resp_count", 32'(recs.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < recs.size()) begin
        chk($sformatf("resp%0d_cycle", i), 32'(recs[i].c), 32'(x_cyc[i]));
        chk($sformatf("resp%0d_rdata", i), recs[i].rd, x_rd[i]);
        chk($sformatf("resp%0d_err", i), 32'(recs[i].er), 32'(x_er[i]));
        chk($sformatf("resp%0d_access_cycles", i), 32'(recs[i].acc), 32'(x_acc[i]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, meaning paddr/addr width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, meaning pwdata/prdata/wdata/rdata width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning max ACCESS cycles before abort (0 disables timeout).
REQ-004 SHALL run on one clock with an asynchronous, active-low reset: clk  input  1  clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have the core-side ports: req  input  1  request; gnt  output  1  grant; we  input  1  write=1; addr  input  APB_ADDR_WIDTH  byte address; wdata  input  APB_DATA_WIDTH  write data; rvalid  output  1  response valid; rdata  output  APB_DATA_WIDTH  read data; err  output  1  error response.
REQ-006 SHALL have the APB master ports: paddr  output  APB_ADDR_WIDTH; pwdata  output  APB_DATA_WIDTH; pwrite  output  1; psel  output  1; penable  output  1; prdata  input  APB_DATA_WIDTH; pready  input  1; pslverr  input  1.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-008 gnt SHALL be combinational: gnt = req AND state==IDLE; the request is accepted on the cycle req&gnt is high.
REQ-009 On acceptance, addr/wdata/we SHALL be registered, and paddr/pwdata/pwrite SHALL hold these registered values stably until the transfer ends.
REQ-010 An accepted address inside the peripheral window 0x1A10_0000..0x1A11_7FFF (inclusive) SHALL go IDLE->SETUP.
REQ-011 An accepted address outside the window SHALL go IDLE->RESP without asserting psel, giving err=1 and rdata=0.
REQ-012 In SETUP, psel SHALL be 1 and penable 0 for exactly one cycle, then the FSM SHALL go to ACCESS.
REQ-013 In ACCESS, psel=1 and penable=1 SHALL hold until pready=1 is sampled.
REQ-014 On pready=1, rdata SHALL capture prdata (reads only; 0 for writes), err SHALL capture pslverr, and the FSM SHALL go to RESP.
REQ-015 In RESP, rvalid SHALL be 1 for exactly one cycle, psel=penable=0, and the FSM SHALL then return to IDLE.
REQ-016 Minimum latency SHALL be: acceptance at cycle N, SETUP at N+1, ACCESS with pready at N+2, rvalid at N+3.
REQ-017 The timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-018 When the counter reaches TIMEOUT_CYCLES, the transfer SHALL abort: ACCESS->RESP with err=1 and rdata=0.
REQ-019 pready arriving on the same cycle as the timeout SHALL win: normal completion.
REQ-020 gnt SHALL be 0 in SETUP, ACCESS and RESP; back-to-back requests SHALL therefore be accepted no earlier than the cycle after RESP.
REQ-021 The counter SHALL be wide enough for TIMEOUT_CYCLES with no wrap-around (saturating).

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rvalid=0, rdata=0, err=0, counter=0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer with no rvalid issued.
REQ-024 The first acceptance after reset release SHALL be possible on the first clock edge with rst_n high.

Structure
REQ-025 Package apb_master_pkg SHALL hold the state enum and the window constants PERIPH_START_ADDR=0x1A10_0000 and PERIPH_END_ADDR=0x1A11_7FFF.
REQ-026 The timeout SHALL be implemented as the sub-module apb_timeout_counter (inputs: clear, enable; output: expired).
REQ-027 The bridge SHALL be connectable to an APB_BUS Master modport through its flat ports.

Verification
REQ-028 Read to 0x1A10_1000 with pready=1 in the first ACCESS cycle and prdata=0xCAFE_F00D SHALL give rvalid at N+3, rdata=0xCAFE_F00D, err=0.
REQ-029 Write 0x1234_5678 to 0x1A10_3004 with pready delayed 5 cycles SHALL hold psel/penable for 6 ACCESS cycles, keep paddr/pwdata stable throughout, and end with rvalid, err=0.
REQ-030 Read to 0x2000_0000 SHALL give rvalid at N+1, err=1, rdata=0, and psel never asserted.
REQ-031 With TIMEOUT_CYCLES=8 and pready held 0, the transfer SHALL abort after 8 ACCESS cycles with err=1, rdata=0; pready=1 on exactly cycle 8 SHALL complete normally.
REQ-032 A pslverr=1 response from the slave at 0x1A11_7FFC SHALL give err=1; a back-to-back req held high SHALL get its second gnt on the cycle after rvalid.
REQ-033 Asserting rst_n=0 during ACCESS SHALL drop psel/penable immediately, produce no rvalid, and allow the next request to be accepted normally after reset release.
